// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the regfile_sb register file and its busy scoreboard.
package regfile_sb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Write ports are applied in ascending index order, so the higher index wins a collision.
    localparam int NPORTS      = 2;
    localparam int PORT_ALU    = 0;
    localparam int PORT_MULDIV = 1;

    function automatic int addr_width(input int nreg);
        return (nreg > 2) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits for long-latency writebacks: mark from decode, clear from the mul/div port.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int NREG = 32,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            mark_en,
    input  logic [AW-1:0]   mark_rd,
    input  logic            we1,
    input  logic [AW-1:0]   rd1,
    output logic            mark_ok,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d  = busy_q;
        mark_ok = 1'b0;

        if (run && we1 && (rd1 != '0)) begin
            busy_d[rd1] = 1'b0;
        end

        // A register being written back this cycle may be re-marked immediately.
        if (run && mark_en &&
            ((mark_rd == '0) || !busy_q[mark_rd] || (we1 && (rd1 == mark_rd)))) begin
            mark_ok = 1'b1;
        end

        if (mark_ok && (mark_rd != '0)) begin
            busy_d[mark_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with sequential clear, two write ports, optional bypass and busy scoreboard.
// Optional REGFILE_SB_TRACE_EN adds dbg_busy_vec and simulation write/mark tracing.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clear sweep: regs[clear_ptr] <= 0 each cycle, ports ignored
// ST_RUN  | normal operation: writes, reads, scoreboard active
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            init_done,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we0,
    input  logic [AW-1:0]   rd0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   rd1,
    input  logic [XLEN-1:0] wd1,
    input  logic            mark_en,
    input  logic [AW-1:0]   mark_rd,
    output logic            mark_ok
`ifdef REGFILE_SB_TRACE_EN
    ,
    output logic [NREG-1:0] dbg_busy_vec
`endif
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clear_ptr_q, clear_ptr_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            run;

    logic [NPORTS-1:0] wr_en;
    logic [NPORTS-1:0] commit;
    logic [AW-1:0]     wr_rd  [NPORTS];
    logic [XLEN-1:0]   wr_dat [NPORTS];

    logic [AW-1:0]     rd_addr [2];
    logic [XLEN-1:0]   rd_val  [2];
    logic [1:0]        rd_busy;
    logic [NREG-1:0]   busy_vec;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;

    always_comb begin
        wr_en[PORT_ALU]     = we0;
        wr_rd[PORT_ALU]     = rd0;
        wr_dat[PORT_ALU]    = wd0;
        wr_en[PORT_MULDIV]  = we1;
        wr_rd[PORT_MULDIV]  = rd1;
        wr_dat[PORT_MULDIV] = wd1;
    end

    // x0 writes are dropped; on an address collision the mul/div port owns the register.
    always_comb begin
        commit = '0;
        for (int p = 0; p < NPORTS; p++) begin
            commit[p] = run && wr_en[p] && (wr_rd[p] != '0);
        end
        if (commit[PORT_MULDIV] && (wr_rd[PORT_ALU] == wr_rd[PORT_MULDIV])) begin
            commit[PORT_ALU] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        regs_d      = regs_q;
        case (state_q)
            ST_INIT: begin
                regs_d[clear_ptr_q] = '0;
                if (clear_ptr_q == AW'(NREG - 1)) begin
                    state_d     = ST_RUN;
                    clear_ptr_d = '0;
                end else begin
                    clear_ptr_d = clear_ptr_q + AW'(1);
                end
            end
            ST_RUN: begin
                for (int p = 0; p < NPORTS; p++) begin
                    if (commit[p]) begin
                        regs_d[wr_rd[p]] = wr_dat[p];
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    // Storage has no reset of its own; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    regfile_sb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mark_en  (mark_en),
        .mark_rd  (mark_rd),
        .we1      (we1),
        .rd1      (rd1),
        .mark_ok  (mark_ok),
        .busy_vec (busy_vec)
    );

    assign rd_addr[0] = rs1;
    assign rd_addr[1] = rs2;

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rd_val[r]  = '0;
            rd_busy[r] = 1'b0;
            if (run && (rd_addr[r] != '0)) begin
                rd_val[r]  = regs_q[rd_addr[r]];
                rd_busy[r] = busy_vec[rd_addr[r]];
                if (BYPASS) begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (commit[p] && (wr_rd[p] == rd_addr[r])) begin
                            rd_val[r] = wr_dat[p];
                        end
                    end
                    // The completing writeback makes the operand ready in the same cycle.
                    if (commit[PORT_MULDIV] && (wr_rd[PORT_MULDIV] == rd_addr[r])) begin
                        rd_busy[r] = 1'b0;
                    end
                end
            end
        end
    end

    assign rs1_val  = rd_val[0];
    assign rs2_val  = rd_val[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];

`ifdef REGFILE_SB_TRACE_EN
    assign dbg_busy_vec = busy_vec;

    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (commit[p]) begin
                    $display("regfile_sb: write port=%0d rd=%0d data=%h t=%0t",
                             p, wr_rd[p], wr_dat[p], $time);
                end
            end
            if (mark_ok) begin
                $display("regfile_sb: mark rd=%0d t=%0t", mark_rd, $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: BYPASS=1 and BYPASS=0 instances share stimulus and a behavioural model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            we0 = 1'b0, we1 = 1'b0, mark_en = 1'b0;
    logic [AW-1:0]   rd0 = '0, rd1 = '0, mark_rd = '0, rs1 = '0, rs2 = '0;
    logic [XLEN-1:0] wd0 = '0, wd1 = '0;

    logic            init_done_a, rs1_busy_a, rs2_busy_a, mark_ok_a;
    logic [XLEN-1:0] rs1_val_a, rs2_val_a;
    logic            init_done_b, rs1_busy_b, rs2_busy_b, mark_ok_b;
    logic [XLEN-1:0] rs1_val_b, rs2_val_b;
`ifdef REGFILE_SB_TRACE_EN
    logic [NREG-1:0] dbg_a, dbg_b;
`endif

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .init_done(init_done_a),
        .rs1(rs1), .rs2(rs2), .rs1_val(rs1_val_a), .rs2_val(rs2_val_a),
        .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a),
        .we0(we0), .rd0(rd0), .wd0(wd0), .we1(we1), .rd1(rd1), .wd1(wd1),
        .mark_en(mark_en), .mark_rd(mark_rd), .mark_ok(mark_ok_a)
`ifdef REGFILE_SB_TRACE_EN
        , .dbg_busy_vec(dbg_a)
`endif
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .init_done(init_done_b),
        .rs1(rs1), .rs2(rs2), .rs1_val(rs1_val_b), .rs2_val(rs2_val_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .we0(we0), .rd0(rd0), .wd0(wd0), .we1(we1), .rd1(rd1), .wd1(wd1),
        .mark_en(mark_en), .mark_rd(mark_rd), .mark_ok(mark_ok_b)
`ifdef REGFILE_SB_TRACE_EN
        , .dbg_busy_vec(dbg_b)
`endif
    );

    // Behavioural model: architectural contents, busy flags, and a sweep cycle count.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    bit              m_run   = 1'b0;
    int              m_sweep = 0;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    function automatic logic exp_mark_ok();
        return m_run && mark_en &&
               (mark_rd == 0 || !m_busy[mark_rd] || (we1 && rd1 == mark_rd));
    endfunction

    function automatic logic [XLEN-1:0] exp_val(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return '0;
        if (byp && we1 && rd1 == a) return wd1;
        if (byp && we0 && rd0 == a) return wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return 1'b0;
        if (byp && we1 && rd1 == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(posedge clk) begin
        logic ok;
        ok = exp_mark_ok();
        if (rst) begin
            m_run   = 1'b0;
            m_sweep = 0;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_sweep++;
            if (m_sweep == NREG) begin
                m_run = 1'b1;
                for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            end
        end else begin
            if (we0 && rd0 != 0 && !(we1 && rd1 == rd0)) m_regs[rd0] = wd0;
            if (we1 && rd1 != 0) begin
                m_regs[rd1] = wd1;
                m_busy[rd1] = 1'b0;
            end
            if (ok && mark_rd != 0) m_busy[mark_rd] = 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            cmp("init_done_a", 32'(init_done_a), 32'(m_run));
            cmp("init_done_b", 32'(init_done_b), 32'(m_run));
            cmp("rs1_val_a",   rs1_val_a, exp_val(rs1, 1'b1));
            cmp("rs2_val_a",   rs2_val_a, exp_val(rs2, 1'b1));
            cmp("rs1_val_b",   rs1_val_b, exp_val(rs1, 1'b0));
            cmp("rs2_val_b",   rs2_val_b, exp_val(rs2, 1'b0));
            cmp("rs1_busy_a",  32'(rs1_busy_a), 32'(exp_busy(rs1, 1'b1)));
            cmp("rs2_busy_a",  32'(rs2_busy_a), 32'(exp_busy(rs2, 1'b1)));
            cmp("rs1_busy_b",  32'(rs1_busy_b), 32'(exp_busy(rs1, 1'b0)));
            cmp("rs2_busy_b",  32'(rs2_busy_b), 32'(exp_busy(rs2, 1'b0)));
            cmp("mark_ok_a",   32'(mark_ok_a), 32'(exp_mark_ok()));
            cmp("mark_ok_b",   32'(mark_ok_b), 32'(exp_mark_ok()));
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                           : AW'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        we0     = 1'($urandom_range(0, 1));
        rd0     = rand_addr();
        wd0     = $urandom;
        we1     = ($urandom_range(0, 3) == 0);
        rd1     = rand_addr();
        wd1     = $urandom;
        mark_en = ($urandom_range(0, 2) == 0);
        mark_rd = rand_addr();
        rs1     = rand_addr();
        rs2     = rand_addr();
    endtask

    task automatic nxt();
        @(negedge clk);
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; mark_en = 1'b0;
        rd0 = '0; rd1 = '0; mark_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic rand_phase(input int n);
        repeat (n) begin
            @(negedge clk);
            rand_inputs();
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle reset pulse; optionally re-reset after abort_at sweep cycles; then time the sweep.
    task automatic do_sweep(input int abort_at, input string tag);
        int cycles;
        @(negedge clk); rand_inputs(); rst = 1'b1;
        @(negedge clk); rand_inputs(); rst = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at) begin
                @(negedge clk); rand_inputs();
            end
            rst = 1'b1;
            @(negedge clk); rand_inputs(); rst = 1'b0;
        end
        cycles = 0;
        do begin
            @(negedge clk); rand_inputs();
            #3;
            cycles++;
        end while (!init_done_a && cycles < 40);
        cmp(tag, 32'(cycles), 32'd32);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_sweep(0, "sweep_first");
        rand_phase(300);
        do_sweep(0, "sweep_len");

        for (int i = 0; i < NREG; i++) begin
            nxt(); rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
            #3;
            cmp("cleared_a", rs1_val_a, 32'h0);
            cmp("cleared_b", rs2_val_b, 32'h0);
        end

        nxt(); we0 = 1; rd0 = 5; wd0 = 32'h11111111; we1 = 1; rd1 = 5; wd1 = 32'h22222222; rs1 = 5;
        #3; cmp("coll_bypass", rs1_val_a, 32'h22222222); cmp("coll_nobypass", rs1_val_b, 32'h0);
        nxt(); rs1 = 5;
        #3; cmp("coll_next_a", rs1_val_a, 32'h22222222); cmp("coll_next_b", rs1_val_b, 32'h22222222);
        nxt(); we0 = 1; rd0 = 0; wd0 = 32'hFFFFFFFF; we1 = 1; rd1 = 0; wd1 = 32'hA5A5A5A5;
        #3; cmp("x0_same", rs1_val_a, 32'h0);
        nxt();
        #3; cmp("x0_after", rs1_val_a, 32'h0);

        nxt(); mark_en = 1; mark_rd = 7;
        #3; cmp("mark7_ok", 32'(mark_ok_a), 32'd1);
        nxt(); mark_en = 1; mark_rd = 7; rs1 = 7;
        #3; cmp("mark7_again", 32'(mark_ok_a), 32'd0); cmp("busy7", 32'(rs1_busy_a), 32'd1);
        nxt(); we1 = 1; rd1 = 7; wd1 = 32'hDEADBEEF; rs1 = 7;
        #3; cmp("busy7_mask_a", 32'(rs1_busy_a), 32'd0);
        cmp("busy7_nomask_b", 32'(rs1_busy_b), 32'd1);
        cmp("wb7_bypass", rs1_val_a, 32'hDEADBEEF);
        nxt(); rs1 = 7;
        #3; cmp("busy7_clr", 32'(rs1_busy_b), 32'd0); cmp("wb7_val_b", rs1_val_b, 32'hDEADBEEF);

        nxt(); mark_en = 1; mark_rd = 9;
        #3; cmp("mark9_ok", 32'(mark_ok_a), 32'd1);
        nxt(); we1 = 1; rd1 = 9; wd1 = 32'h99; mark_en = 1; mark_rd = 9; rs1 = 9;
        #3; cmp("remark9_ok", 32'(mark_ok_a), 32'd1); cmp("busy9_b", 32'(rs1_busy_b), 32'd1);
        nxt(); we0 = 1; rd0 = 9; wd0 = 32'h1234; rs1 = 9;
        #3; cmp("busy9_set", 32'(rs1_busy_a), 32'd1);
        nxt(); rs1 = 9;
        #3; cmp("busy9_p0", 32'(rs1_busy_a), 32'd1); cmp("val9", rs1_val_a, 32'h1234);

        nxt(); we0 = 1; rd0 = 4; wd0 = 32'hCAFE0000; rs1 = 4;
        #3; cmp("nobyp_old", rs1_val_b, 32'h0); cmp("byp_new", rs1_val_a, 32'hCAFE0000);
        nxt(); rs1 = 4;
        #3; cmp("nobyp_next", rs1_val_b, 32'hCAFE0000);

        nxt(); mark_en = 1; mark_rd = 3;
        nxt(); rs1 = 3;
        #3; cmp("busy3_pre", 32'(rs1_busy_a), 32'd1);
        do_sweep(10, "sweep_restart");
        nxt(); rs1 = 3;
        #3; cmp("busy3_post", 32'(rs1_busy_b), 32'd0);

        rand_phase(3000);
        nxt();
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file. Adds a synchronous reset with sequential clear, two write ports (ALU and M-extension mul/div unit), optional write-to-read bypass, and a per-register busy scoreboard for long-latency writebacks.
- Sits between decode (read and mark), the single-cycle ALU writeback (port 0) and the multi-cycle mul/div writeback (port 1).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2. Register 0 is hardwired to zero.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the registered value only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sweep has finished.
- rs1, rs2  in  AW  read addresses; AW = $clog2(NREG).
- rs1_val, rs2_val  out  XLEN  combinational read data.
- rs1_busy, rs2_busy  out  1  the register has a pending long-latency write.
- we0  in  1  write enable, port 0 (ALU).
- rd0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (mul/div).
- rd1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- mark_en  in  1  request to set the busy bit of mark_rd.
- mark_rd  in  AW  register to mark.
- mark_ok  out  1  combinational; the mark request is accepted this cycle.

Behaviour:
- FSM states INIT and RUN.
- Reset:
  - rst=1 forces INIT, clear_ptr=0, all busy bits=0 and init_done=0.
  - rst asserted mid-sweep or mid-operation restarts the sweep from 0.
- INIT:
  - Each cycle writes 0 to regs[clear_ptr] and increments clear_ptr.
  - After the write to NREG-1 the FSM moves to RUN; init_done=1 from the next cycle. The sweep takes NREG cycles after rst deasserts.
  - During INIT: we0, we1 and mark_en are ignored, mark_ok=0, rs*_val=0, rs*_busy=0.
- RUN writes:
  - A write to register 0 on either port is discarded.
  - we0 and we1 to the same nonzero rd in the same cycle: port 1 wins and port 0 is dropped.
  - Writes take effect at the posedge; there is no read-after-write latency beyond that.
- Reads:
  - Address 0 always returns 0.
  - BYPASS=1: if the read address matches an active write this cycle, the read returns that write's data, with port 1 taking priority over port 0. Otherwise it returns the registered value.
  - BYPASS=0: reads return the registered value.
- Scoreboard:
  - we1 to rd1 != 0 clears busy[rd1] at the posedge. Port 0 never touches busy bits.
  - mark_ok = RUN && mark_en && (mark_rd==0 || !busy[mark_rd] || (we1 && rd1==mark_rd)).
  - When mark_ok=1 and mark_rd != 0, busy[mark_rd] is set at the posedge.
  - Simultaneous clear and set of the same register: set wins, busy stays 1.
  - A mark to register 0 is accepted and has no effect.
  - rs*_busy = busy[rs*] && rs* != 0. With BYPASS=1 it is additionally masked to 0 when we1 writes the same register this cycle.
- Arithmetic: clear_ptr is AW bits wide; the INIT->RUN transition happens when clear_ptr==NREG-1, so the pointer never wraps.

Optional Feature:
- Macro REGFILE_SB_TRACE_EN.
- Defined: adds output port dbg_busy_vec [NREG-1:0] carrying the raw busy bits, and a simulation-only $display of every committed write (port, rd, data, $time) and every accepted mark.
- Undefined: no dbg_busy_vec port and no display statements; the rest of the block is functionally identical.

Decomposition:
- Package regfile_sb_pkg holds:
  - the state encoding (ST_INIT, ST_RUN);
  - the port-priority constants;
  - the address-width function clog2-based AW.
- One sub-module, regfile_sb_scoreboard, holds the busy vector, mark/clear arbitration and the mark_ok logic. The storage array and bypass muxing stay in the top module.

Test Plan:
- Reset sweep: NREG=32, pulse rst for 1 cycle after preloading garbage -> init_done rises exactly 32 cycles after rst falls; every register reads 0; mark_ok=0 throughout INIT.
- Dual-port collision: we0 and we1 both to rd=5, wd0=0x11111111, wd1=0x22222222 -> with BYPASS=1, rs1=5 reads 0x22222222 in the same cycle; the next cycle reads 0x22222222. A write to rd=0 leaves x0 reading 0.
- Scoreboard: mark x7 -> rs1_busy=1 for rs1=7; a second mark of x7 gives mark_ok=0; we1 to rd1=7 with 0xDEADBEEF -> busy clears and rs1_val=0xDEADBEEF.
- Simultaneous clear and re-mark of x9 in one cycle -> mark_ok=1, busy[9] stays 1; a port-0 write to x9 does not clear it.
- Reset mid-operation: rst during RUN with busy[3]=1 and mid-sweep at clear_ptr=10 -> the sweep restarts at 0, busy is all zero, and init_done=0 until 32 cycles later.
- BYPASS=0 build: write x4=0xCAFE0000 and read x4 in the same cycle -> returns the old value; the next cycle returns 0xCAFE0000.
